// File: rtl/sift_desc_pkg.sv
// Shared constants and fixed-point helpers for the SIFT descriptor coordinate path.
package sift_desc_pkg;

    localparam int  WIN_DEF      = 16;
    localparam int  ANG_BINS_DEF = 36;
    localparam real PI           = 3.14159265358979323846;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Q1.FRAC_W trig constants need a sign bit plus the integer bit for +/-1.0.
    function automatic int trig_w(input int frac_w);
        return frac_w + 2;
    endfunction

    // Round-half-up of s / 2^(frac_w+1), then clamp into a coord_w-bit signed range.
    function automatic int round_sat(input longint s, input int frac_w, input int coord_w);
        longint t;
        longint hi;
        longint lo;
        t  = (s + (longint'(1) <<< frac_w)) >>> (frac_w + 1);
        hi = (longint'(1) <<< (coord_w - 1)) - 1;
        lo = -hi - 1;
        if (t > hi)      t = hi;
        else if (t < lo) t = lo;
        return int'(t);
    endfunction

endpackage

// File: rtl/sift_trig_rom.sv
// Combinational cos/sin table for all orientation bins, built at elaboration time.
module sift_trig_rom
    import sift_desc_pkg::*;
#(
    parameter int ANG_BINS = ANG_BINS_DEF,
    parameter int ANG_W    = 6,
    parameter int FRAC_W   = 10
) (
    input  logic        [ANG_W-1:0]          ang_i,
    output logic signed [trig_w(FRAC_W)-1:0] cos_o,
    output logic signed [trig_w(FRAC_W)-1:0] sin_o
);

    localparam int TRIG_W = trig_w(FRAC_W);

    function automatic logic signed [TRIG_W-1:0] trig_const(input int k, input bit is_sin);
        real th;
        real v;
        th = 2.0 * PI * real'(k) / real'(ANG_BINS);
        v  = (is_sin ? $sin(th) : $cos(th)) * real'(1 << FRAC_W);
        return TRIG_W'($rtoi($floor(v + 0.5)));
    endfunction

    logic signed [TRIG_W-1:0] cos_tab [2**ANG_W];
    logic signed [TRIG_W-1:0] sin_tab [2**ANG_W];

    // Unused addresses alias bin 0 so the table covers the full index space.
    for (genvar k = 0; k < 2**ANG_W; k++) begin : g_tab
        assign cos_tab[k] = trig_const((k < ANG_BINS) ? k : 0, 1'b0);
        assign sin_tab[k] = trig_const((k < ANG_BINS) ? k : 0, 1'b1);
    end

    assign cos_o = cos_tab[ang_i];
    assign sin_o = sin_tab[ang_i];

endmodule

// File: rtl/sift_rot_coord_gen.sv
// Raster-scans a WIN x WIN window and streams each sample's rotated, rounded,
// saturated centre-relative coordinate through a two-stage stallable pipeline.
module sift_rot_coord_gen
    import sift_desc_pkg::*;
#(
    parameter int WIN      = WIN_DEF,
    parameter int ANG_BINS = ANG_BINS_DEF,
    parameter int ANG_W    = 6,
    parameter int FRAC_W   = 10,
    parameter int COORD_W  = 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic        [ANG_W-1:0]     ang,
    output logic                        busy,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic        [$clog2(WIN)-1:0] out_row,
    output logic        [$clog2(WIN)-1:0] out_col,
    output logic signed [COORD_W-1:0]   rx,
    output logic signed [COORD_W-1:0]   ry,
    output logic                        out_last,
    output logic                        done
);

    localparam int AW     = $clog2(WIN);
    localparam int DW     = AW + 1;
    localparam int TRIG_W = trig_w(FRAC_W);
    localparam int PW     = TRIG_W + DW;
    localparam int SW     = PW + 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(WIN - 1);

    logic [1:0]       state_q, state_d;
    logic [AW-1:0]    r_q, r_d, c_q, c_d;
    logic [ANG_W-1:0] ang_q;

    logic                     s1_valid_q;
    logic signed [TRIG_W-1:0] s1_cos_q, s1_sin_q;
    logic signed [DW-1:0]     s1_dc_q, s1_dr_q;
    logic [AW-1:0]            s1_row_q, s1_col_q;
    logic                     s1_last_q;

    logic signed [TRIG_W-1:0] rom_cos, rom_sin;
    logic signed [DW-1:0]     dc, dr;
    logic signed [SW-1:0]     sx, sy;
    logic advance, start_acc, issue, at_end, hs_last;

    sift_trig_rom #(
        .ANG_BINS (ANG_BINS),
        .ANG_W    (ANG_W),
        .FRAC_W   (FRAC_W)
    ) u_rom (
        .ang_i (ang_q),
        .cos_o (rom_cos),
        .sin_o (rom_sin)
    );

    // 2k+1-WIN modulo 2*WIN is {k,1} with its top bit flipped; the result fits DW signed bits.
    assign dc = {~c_q[AW-1], c_q[AW-2:0], 1'b1};
    assign dr = {~r_q[AW-1], r_q[AW-2:0], 1'b1};

    assign advance   = !out_valid | out_ready;
    assign start_acc = start && (state_q == ST_IDLE);
    assign issue     = (state_q == ST_SCAN) && advance;
    assign at_end    = (r_q == LAST_IDX) && (c_q == LAST_IDX);
    assign hs_last   = out_valid && out_ready && out_last;

    assign busy = (state_q != ST_IDLE);
    assign done = hs_last;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        c_d     = c_q;
        case (state_q)
            ST_IDLE: if (start) begin
                state_d = ST_SCAN;
                r_d     = '0;
                c_d     = '0;
            end
            ST_SCAN: if (advance) begin
                if (at_end) state_d = ST_DRAIN;
                c_d = (c_q == LAST_IDX) ? '0 : c_q + 1'b1;
                if (c_q == LAST_IDX) r_d = r_q + 1'b1;
            end
            ST_DRAIN: if (hs_last) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign sx = SW'(PW'(s1_cos_q) * PW'(s1_dc_q)) + SW'(PW'(s1_sin_q) * PW'(s1_dr_q));
    assign sy = SW'(PW'(s1_cos_q) * PW'(s1_dr_q)) - SW'(PW'(s1_sin_q) * PW'(s1_dc_q));

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            r_q     <= '0;
            c_q     <= '0;
            ang_q   <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            c_q     <= c_d;
            if (start_acc) ang_q <= (int'(ang) < ANG_BINS) ? ang : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_cos_q   <= '0;
            s1_sin_q   <= '0;
            s1_dc_q    <= '0;
            s1_dr_q    <= '0;
            s1_row_q   <= '0;
            s1_col_q   <= '0;
            s1_last_q  <= 1'b0;
        end else if (advance) begin
            s1_valid_q <= issue;
            if (issue) begin
                s1_cos_q  <= rom_cos;
                s1_sin_q  <= rom_sin;
                s1_dc_q   <= dc;
                s1_dr_q   <= dr;
                s1_row_q  <= r_q;
                s1_col_q  <= c_q;
                s1_last_q <= at_end;
            end
        end
    end

    // Output fields load only with a valid beat, so they hold through stalls and idle gaps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_row   <= '0;
            out_col   <= '0;
            rx        <= '0;
            ry        <= '0;
            out_last  <= 1'b0;
        end else if (advance) begin
            out_valid <= s1_valid_q;
            if (s1_valid_q) begin
                out_row  <= s1_row_q;
                out_col  <= s1_col_q;
                rx       <= COORD_W'(round_sat(longint'(sx), FRAC_W, COORD_W));
                ry       <= COORD_W'(round_sat(longint'(sy), FRAC_W, COORD_W));
                out_last <= s1_last_q;
            end
        end
    end

endmodule

// File: doc/sift_rot_coord_gen.md
Name: sift_rot_coord_gen

Overview:
Sequential, parametrised generator of rotated sample coordinates for the SIFT descriptor stage. On a start pulse it latches a keypoint orientation bin and raster-scans a WIN x WIN sample window. For every sample it emits the centre-relative coordinate rotated by that orientation, rounded and saturated. It replaces the fixed per-angle combinational coordinate ROMs: one block covers all orientation bins, any window size and any coordinate width, with streaming valid/ready output.

Parameters:
WIN, 16, window side in samples; power of two, 4..32.
ANG_BINS, 36, number of orientation bins; bin k = 2*pi*k/ANG_BINS.
ANG_W, 6, width of orientation index; 2^ANG_W >= ANG_BINS.
FRAC_W, 10, fractional bits of the trig constants (Q1.FRAC_W signed).
COORD_W, 5, signed output coordinate width.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request; accepted only when busy=0
ang  in  ANG_W  orientation bin, sampled on accepted start
busy  out  1  high from accepted start until last beat accepted
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts beat when out_valid&out_ready
out_row  out  log2(WIN)  source row r of the beat
out_col  out  log2(WIN)  source column c of the beat
rx  out  COORD_W  rotated x, two's complement
ry  out  COORD_W  rotated y, two's complement
out_last  out  1  marks beat r=c=WIN-1
done  out  1  one-cycle pulse on the cycle the last beat is accepted

Behaviour:
- Reset: asynchronous on rst_n low, regardless of clk. All outputs 0, FSM IDLE, counters 0, pipeline valids cleared. A reset during a scan aborts it; no done pulse.
- FSM states: IDLE -> SCAN on start&!busy; SCAN -> DRAIN when (r,c)=(WIN-1,WIN-1) is issued; DRAIN -> IDLE when the last beat is accepted.
- busy=1 in SCAN and DRAIN. start while busy is ignored; ang is not re-sampled.
- ang >= ANG_BINS at start is mapped to bin 0.
- Scan order: c increments fastest. c wraps WIN-1 -> 0 with r+1. Exactly WIN*WIN beats per start.
- Pipeline: stage 1 is the trig lookup plus dc/dr; stage 2 is multiply-add, round, saturate. The first beat's out_valid rises 2 cycles after the start cycle when out_ready=1.
- Stall rule: advance = !out_valid | out_ready. Counters and both stages hold when advance=0. Output fields stay stable while out_valid&!out_ready. No beat is dropped or duplicated.
- Throughput: 1 beat/cycle with out_ready held high.
- Arithmetic:
  - dc = 2c-(WIN-1), dr = 2r-(WIN-1), both signed, in half-sample units.
  - C = round(cos(theta)*2^FRAC_W), S = round(sin(theta)*2^FRAC_W).
  - Sx = C*dc + S*dr; Sy = C*dr - S*dc. Full-precision signed products.
  - rx = (Sx + 2^FRAC_W) >>> (FRAC_W+1), i.e. round-half-up of Sx/2^(FRAC_W+1). ry is computed the same way from Sy.
  - Saturate to [-2^(COORD_W-1), 2^(COORD_W-1)-1]. No wrap-around.
- done pulses on the cycle the out_last beat handshakes. A new start is accepted from the following cycle (busy already 0).
- out_valid deasserts after the last handshake unless a new scan has filled the pipeline.

Decomposition:
- Shared package sift_desc_pkg holds: trig constant width (FRAC_W+2), the rounding/saturation function, and the ANG_BINS/WIN defaults.
- Sub-module sift_trig_rom: combinational distributed ROM, address ang, outputs signed C and S. Generated from ANG_BINS and FRAC_W by a constant function, not hand-listed.

Test Plan:
- ang=0, out_ready=1: first beat (r0,c0) gives rx=-7, ry=-7; beat (0,15) gives rx=8, ry=-7; last beat (15,15) gives rx=8, ry=8 with out_last=1 and done=1. 256 beats total; first out_valid 2 cycles after start.
- ang=9 (90 deg): beat (r0,c15) gives rx=-7, ry=-7; beat (r15,c0) gives rx=8, ry=8. Compare every beat against a golden model.
- Random out_ready (50%) at ang=5: beat sequence identical to the out_ready=1 run; outputs held stable during stalls; done only on the final handshake.
- start pulsed mid-scan with ang=20: ignored. The scan completes with the ang=5 values, and the count stays at 256.
- rst_n low at beat 100, asynchronously between clock edges: all outputs 0 immediately, no done. A start after release begins again at (0,0).
- COORD_W=4 build, ang=4 (40 deg): corner beats saturate to +7/-8; the golden model confirms the clamped values.
